// File: rtl/meikyuu_pkg.sv
// Screen geometry, room-grid size and the FSM/direction encodings shared by the maze player logic.
package meikyuu_pkg;
  localparam int H_MIN  = 97;
  localparam int H_MAX  = 736;
  localparam int V_MIN  = 3;
  localparam int V_MAX  = 482;
  localparam int SPRITE = 16;
  localparam int MAP_W  = 3;
  localparam int MAP_H  = 3;

  localparam logic [9:0] X_HOME    = 10'd409;
  localparam logic [9:0] Y_HOME    = 10'd235;
  localparam logic [2:0] ROOM_HOME = 3'd1;

  typedef enum logic [1:0] {IDLE, PROBE, COMMIT, EDGE} state_t;
  typedef enum logic [2:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_NONE} dir_t;

  // Button vector order is {right, left, down, up}; lowest set bit wins.
  function automatic dir_t first_dir(input logic [3:0] btn);
    if (btn[0]) return DIR_UP;
    if (btn[1]) return DIR_DOWN;
    if (btn[2]) return DIR_LEFT;
    if (btn[3]) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  // Signed compare so an underflowed candidate counts as off-screen.
  function automatic logic span_fits(input logic signed [10:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) + SPRITE - 1 <= hi);
  endfunction
endpackage

// File: rtl/player_motion_ctrl_if.sv
// Probe/collision handshake between the motion controller and the top level's wall logic.
interface player_motion_ctrl_if;
  logic [9:0] probe_x_out;
  logic [9:0] probe_y_out;
  logic       probe_valid;
  logic       collision;

  modport master (output probe_x_out, probe_y_out, probe_valid, input collision);
  modport slave  (input probe_x_out, probe_y_out, probe_valid, output collision);
endinterface

// File: rtl/btn_sync.sv
// Per-bit two-flop synchronizer for the asynchronous direction buttons.
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] synced
);
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign synced[gi] = sync_reg;
    end
  endgenerate
endmodule

// File: rtl/player_motion_ctrl.sv
// Button-driven sprite mover with wall probing and room hand-over at the screen edge.
// Define PLAYER_DIAGONAL_EN to let one vertical and one horizontal button act in the same frame.
module player_motion_ctrl
  import meikyuu_pkg::*;
#(
  parameter int STEP     = 2,
  parameter int COLL_LAT = 2
) (
  input  logic                 CLOCK_25,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  player_motion_ctrl_if.master probe,
  output logic [9:0]           x_pos_out,
  output logic [9:0]           y_pos_out,
  output logic [2:0]           mapa_pos_x_out,
  output logic [2:0]           mapa_pos_y_out,
  output logic                 busy
);
  localparam int                CNT_W    = (COLL_LAT > 1) ? $clog2(COLL_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COLL_LAT - 1);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic [9:0]        X_NEAR   = 10'(H_MIN);
  localparam logic [9:0]        X_FAR    = 10'(H_MAX - SPRITE + 1);
  localparam logic [9:0]        Y_NEAR   = 10'(V_MIN);
  localparam logic [9:0]        Y_FAR    = 10'(V_MAX - SPRITE + 1);
  localparam logic [2:0]        MX_LAST  = 3'(MAP_W - 1);
  localparam logic [2:0]        MY_LAST  = 3'(MAP_H - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_s;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  btn_sync #(.W(4)) u_btn_sync (
    .clk    (CLOCK_25),
    .srst   (reset),
    .raw    (btn_raw),
    .synced (btn_s)
  );

  state_t             state_reg, state_next;
  dir_t               dir_reg, dir_next;
  dir_t               pend_reg, pend_next;
  dir_t               launch;
  logic [9:0]         x_reg, x_next, y_reg, y_next;
  logic [2:0]         mx_reg, mx_next, my_reg, my_next;
  logic [9:0]         cand_x_reg, cand_x_next, cand_y_reg, cand_y_next;
  logic signed [10:0] step_x, step_y;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               probing;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_reg  <= IDLE;
      dir_reg    <= DIR_NONE;
      pend_reg   <= DIR_NONE;
      x_reg      <= X_HOME;
      y_reg      <= Y_HOME;
      mx_reg     <= ROOM_HOME;
      my_reg     <= ROOM_HOME;
      cand_x_reg <= X_HOME;
      cand_y_reg <= Y_HOME;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      pend_reg   <= pend_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      mx_reg     <= mx_next;
      my_reg     <= my_next;
      cand_x_reg <= cand_x_next;
      cand_y_reg <= cand_y_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    pend_next   = pend_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    mx_next     = mx_reg;
    my_next     = my_reg;
    cand_x_next = cand_x_reg;
    cand_y_next = cand_y_reg;
    cnt_next    = cnt_reg;
    launch      = DIR_NONE;
    step_x      = $signed({1'b0, x_reg});
    step_y      = $signed({1'b0, y_reg});

    unique case (state_reg)
      IDLE: begin
        // A pending second axis launches on its own, so frame ticks are ignored until it is done.
        if (pend_reg != DIR_NONE) begin
          launch    = pend_reg;
          pend_next = DIR_NONE;
        end else if (frame_tick) begin
`ifdef PLAYER_DIAGONAL_EN
          launch    = first_dir({2'b00, btn_s[1:0]});
          pend_next = first_dir({btn_s[3:2], 2'b00});
          if (launch == DIR_NONE) begin
            launch    = pend_next;
            pend_next = DIR_NONE;
          end
`else
          launch = first_dir(btn_s);
`endif
        end
      end
      PROBE: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = probe.collision ? IDLE : COMMIT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      COMMIT: begin
        x_next     = cand_x_reg;
        y_next     = cand_y_reg;
        state_next = IDLE;
      end
      EDGE: begin
        state_next = IDLE;
        case (dir_reg)
          DIR_LEFT: begin
            if (mx_reg != 3'd0) begin
              mx_next = mx_reg - 3'd1;
              x_next  = X_FAR;
            end else begin
              x_next = X_NEAR;
            end
          end
          DIR_RIGHT: begin
            if (mx_reg < MX_LAST) begin
              mx_next = mx_reg + 3'd1;
              x_next  = X_NEAR;
            end else begin
              x_next = X_FAR;
            end
          end
          DIR_UP: begin
            if (my_reg != 3'd0) begin
              my_next = my_reg - 3'd1;
              y_next  = Y_FAR;
            end else begin
              y_next = Y_NEAR;
            end
          end
          DIR_DOWN: begin
            if (my_reg < MY_LAST) begin
              my_next = my_reg + 3'd1;
              y_next  = Y_NEAR;
            end else begin
              y_next = Y_FAR;
            end
          end
          default: ;
        endcase
      end
      default: state_next = IDLE;
    endcase

    case (launch)
      DIR_UP:    step_y = step_y - STEP_S;
      DIR_DOWN:  step_y = step_y + STEP_S;
      DIR_LEFT:  step_x = step_x - STEP_S;
      DIR_RIGHT: step_x = step_x + STEP_S;
      default: ;
    endcase

    if (launch != DIR_NONE) begin
      dir_next    = launch;
      cand_x_next = step_x[9:0];
      cand_y_next = step_y[9:0];
      cnt_next    = '0;
      state_next  = (span_fits(step_x, H_MIN, H_MAX) && span_fits(step_y, V_MIN, V_MAX))
                    ? PROBE : EDGE;
    end
  end

  assign probing           = (state_reg == PROBE);
  assign probe.probe_valid = probing;
  assign probe.probe_x_out = probing ? cand_x_reg : x_reg;
  assign probe.probe_y_out = probing ? cand_y_reg : y_reg;

  assign x_pos_out      = x_reg;
  assign y_pos_out      = y_reg;
  assign mapa_pos_x_out = mx_reg;
  assign mapa_pos_y_out = my_reg;
  assign busy           = (state_reg != IDLE) || (pend_reg != DIR_NONE);
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed steps plus random frames against a behavioural model.
module tb_player_motion_ctrl;
  localparam int TB_HMIN = 97;
  localparam int TB_HMAX = 736;
  localparam int TB_VMIN = 3;
  localparam int TB_VMAX = 482;
  localparam int TB_SPR  = 16;
  localparam int TB_STEP = 2;
  localparam int TB_ROOMS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] x_pos, y_pos;
  logic [2:0] mapa_x, mapa_y;
  logic       busy;

  player_motion_ctrl_if pif ();

  player_motion_ctrl dut (
    .CLOCK_25       (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .probe          (pif),
    .x_pos_out      (x_pos),
    .y_pos_out      (y_pos),
    .mapa_pos_x_out (mapa_x),
    .mapa_pos_y_out (mapa_y),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_x, m_y, m_mx, m_my;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 409; m_y = 235; m_mx = 1; m_my = 1;
  endtask

  // One axis move: off-screen candidates change room or clamp, on-screen ones need a clear probe.
  task automatic model_axis(input int d, input bit coll);
    int nx = m_x;
    int ny = m_y;
    case (d)
      0: ny -= TB_STEP;
      1: ny += TB_STEP;
      2: nx -= TB_STEP;
      default: nx += TB_STEP;
    endcase
    if (nx < TB_HMIN) begin
      if (m_mx > 0) begin m_mx--; m_x = TB_HMAX - TB_SPR + 1; end
      else m_x = TB_HMIN;
    end else if (nx + TB_SPR - 1 > TB_HMAX) begin
      if (m_mx < TB_ROOMS - 1) begin m_mx++; m_x = TB_HMIN; end
      else m_x = TB_HMAX - TB_SPR + 1;
    end else if (ny < TB_VMIN) begin
      if (m_my > 0) begin m_my--; m_y = TB_VMAX - TB_SPR + 1; end
      else m_y = TB_VMIN;
    end else if (ny + TB_SPR - 1 > TB_VMAX) begin
      if (m_my < TB_ROOMS - 1) begin m_my++; m_y = TB_VMIN; end
      else m_y = TB_VMAX - TB_SPR + 1;
    end else if (!coll) begin
      m_x = nx;
      m_y = ny;
    end
  endtask

  // b = {right, left, down, up}
  task automatic model_frame(input logic [3:0] b, input bit coll);
`ifdef PLAYER_DIAGONAL_EN
    if (b[0]) model_axis(0, coll);
    else if (b[1]) model_axis(1, coll);
    if (b[2]) model_axis(2, coll);
    else if (b[3]) model_axis(3, coll);
`else
    if (b[0]) model_axis(0, coll);
    else if (b[1]) model_axis(1, coll);
    else if (b[2]) model_axis(2, coll);
    else if (b[3]) model_axis(3, coll);
`endif
  endtask

  task automatic set_inputs(input logic [3:0] b, input bit coll);
    btn_up = b[0]; btn_down = b[1]; btn_left = b[2]; btn_right = b[3];
    pif.collision = coll;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"}, 32'(x_pos), m_x);
    check({tag, "_y"}, 32'(y_pos), m_y);
    check({tag, "_mx"}, 32'(mapa_x), m_mx);
    check({tag, "_my"}, 32'(mapa_y), m_my);
  endtask

  task automatic check_home(input string tag);
    check({tag, "_x"}, 32'(x_pos), 32'd409);
    check({tag, "_y"}, 32'(y_pos), 32'd235);
    check({tag, "_mx"}, 32'(mapa_x), 32'd1);
    check({tag, "_my"}, 32'(mapa_y), 32'd1);
    check({tag, "_pvalid"}, 32'(pif.probe_valid), 32'd0);
    check({tag, "_px"}, 32'(pif.probe_x_out), 32'd409);
    check({tag, "_py"}, 32'(pif.probe_y_out), 32'd235);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check_home(tag);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic frame(input logic [3:0] b, input bit coll, input bit extra, input string tag);
    set_inputs(b, coll);
    pulse_tick();
    if (extra) pulse_tick();
    wait_idle(tag);
    model_frame(b, coll);
    check_model(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rb;
    reset = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    pif.collision = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Right step, exact latency: committed on the fourth cycle counted from the tick.
    set_inputs(4'b1000, 1'b0);
    pulse_tick();
    check("lat_pvalid", 32'(pif.probe_valid), 32'd1);
    check("lat_px", 32'(pif.probe_x_out), 32'd411);
    @(negedge clk);
    @(negedge clk);
    check("lat_x_pre", 32'(x_pos), 32'd409);
    check("lat_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_x", 32'(x_pos), 32'd411);
    check("lat_y", 32'(y_pos), 32'd235);
    check("lat_busy", 32'(busy), 32'd0);

    do_reset("reset2");
    frame(4'b0101, 1'b0, 1'b0, "up_left");
`ifndef PLAYER_DIAGONAL_EN
    check("up_left_y", 32'(y_pos), 32'd233);
    check("up_left_x", 32'(x_pos), 32'd409);
`endif

    // Wall hit: probe held for two cycles, position unchanged.
    do_reset("reset3");
    set_inputs(4'b1000, 1'b1);
    pulse_tick();
    check("coll_pv0", 32'(pif.probe_valid), 32'd1);
    check("coll_px0", 32'(pif.probe_x_out), 32'd411);
    @(negedge clk);
    check("coll_pv1", 32'(pif.probe_valid), 32'd1);
    check("coll_px1", 32'(pif.probe_x_out), 32'd411);
    @(negedge clk);
    check("coll_pv2", 32'(pif.probe_valid), 32'd0);
    check("coll_x", 32'(x_pos), 32'd409);
    check("coll_busy", 32'(busy), 32'd0);
    check("coll_px2", 32'(pif.probe_x_out), 32'd409);

    // Second tick while probing must not queue another step.
    frame(4'b1000, 1'b0, 1'b1, "dbl_tick");
    repeat (6) @(negedge clk);
    check("dbl_busy", 32'(busy), 32'd0);
    check("dbl_x", 32'(x_pos), 32'd411);

    // Reset lands in the middle of a probe.
    set_inputs(4'b0010, 1'b0);
    pulse_tick();
    check("rstp_pvalid", 32'(pif.probe_valid), 32'd1);
    do_reset("rst_probe");

    // Walk left to the edge, hand over to room 0, then clamp at the grid boundary.
    for (int i = 0; i < 400 && m_x != 97; i++) frame(4'b0100, 1'b0, 1'b0, "walk_l1");
    check("edge_l_x0", 32'(x_pos), 32'd97);
    frame(4'b0100, 1'b0, 1'b0, "edge_l");
    check("edge_l_mx", 32'(mapa_x), 32'd0);
    check("edge_l_x", 32'(x_pos), 32'd721);
    for (int i = 0; i < 400 && m_x != 97; i++) frame(4'b0100, 1'b0, 1'b0, "walk_l2");
    frame(4'b0100, 1'b0, 1'b0, "clamp_l");
    check("clamp_l_mx", 32'(mapa_x), 32'd0);
    check("clamp_l_x", 32'(x_pos), 32'd97);

    repeat (360) frame(4'b0001, 1'b0, 1'b0, "walk_u");
    check("clamp_u_my", 32'(mapa_y), 32'd0);
    check("clamp_u_y", 32'(y_pos), 32'd3);
    repeat (720) frame(4'b0010, 1'b0, 1'b0, "walk_d");
    check("clamp_d_my", 32'(mapa_y), 32'd2);
    check("clamp_d_y", 32'(y_pos), 32'd467);
    repeat (950) frame(4'b1000, 1'b0, 1'b0, "walk_r");
    check("clamp_r_mx", 32'(mapa_x), 32'd2);
    check("clamp_r_x", 32'(x_pos), 32'd721);

    for (int i = 0; i < 300; i++) begin
      rb = 4'($urandom_range(0, 15));
      frame(rb, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
